// File: rtl/game_pkg.sv
// game_pkg: shared FSM encoding, grid defaults and bit-vector helpers for the card game
package game_pkg;

    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;
    localparam int DEF_IDW  = 3;
    localparam int MAXN     = 64;

    typedef enum logic [4:0] {
        IDLE     = 5'b00001,
        ONE      = 5'b00010,
        HOLD     = 5'b00100,
        JUDGE    = 5'b01000,
        WAIT_CLR = 5'b10000
    } state_t;

    function automatic int popcount(input logic [MAXN-1:0] v);
        int c = 0;
        for (int i = 0; i < MAXN; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int lo_idx(input logic [MAXN-1:0] v);
        int k = 0;
        for (int i = MAXN - 1; i >= 0; i--) if (v[i]) k = i;
        return k;
    endfunction

    function automatic int hi_idx(input logic [MAXN-1:0] v);
        int k = 0;
        for (int i = 0; i < MAXN; i++) if (v[i]) k = i;
        return k;
    endfunction

endpackage

// File: rtl/match_ctrl_if.sv
// match_ctrl_if: controller <-> card array bundle (cursor, strobes, card status and IDs)
interface match_ctrl_if #(
    parameter int N   = game_pkg::DEF_ROWS * game_pkg::DEF_COLS,
    parameter int IDW = game_pkg::DEF_IDW
);
    logic [N-1:0]     cur;
    logic             s;
    logic             mf;
    logic             ms;
    logic [N-1:0]     sel;
    logic [N-1:0]     hidden;
    logic [N*IDW-1:0] card_id;

    modport master (output cur, s, mf, ms, input sel, hidden, card_id);
    modport slave  (input cur, s, mf, ms, output sel, hidden, card_id);
endinterface

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: wrapping row/col cursor with u>d>l>r move priority and one-hot output
module cursor_ctrl
    import game_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           btn_u,
    input  logic                           btn_d,
    input  logic                           btn_l,
    input  logic                           btn_r,
    output logic [$clog2(ROWS*COLS)-1:0]   idx,
    output logic [ROWS*COLS-1:0]           cur
);
    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int XW = $clog2(N);

    logic [RW-1:0] row, row_n;
    logic [CW-1:0] col, col_n;
    logic [XW-1:0] idx_n;

    // apply at most one move, vertical moves win over horizontal ones
    always_comb begin
        row_n = btn_u ? ((row == '0) ? RW'(ROWS - 1) : row - 1'b1) :
                btn_d ? ((row == RW'(ROWS - 1)) ? '0 : row + 1'b1) : row;
        col_n = (btn_u | btn_d) ? col :
                btn_l ? ((col == '0) ? CW'(COLS - 1) : col - 1'b1) :
                btn_r ? ((col == CW'(COLS - 1)) ? '0 : col + 1'b1) : col;
        idx_n = XW'(int'(row_n) * COLS + int'(col_n));
    end

    // cursor position, index and one-hot vector all registered together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
            idx <= '0;
            cur <= N'(1);
        end else begin
            row <= row_n;
            col <= col_n;
            idx <= idx_n;
            cur <= N'(1) << idx_n;
        end
    end
endmodule

// File: rtl/match_ctrl.sv
// match_ctrl: cursor ownership, select gating and pair judgement for the card grid
module match_ctrl
    import game_pkg::*;
#(
    parameter int ROWS        = DEF_ROWS,
    parameter int COLS        = DEF_COLS,
    parameter int IDW         = DEF_IDW,
    parameter int SHOW_CYCLES = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                btn_u,
    input  logic                                btn_d,
    input  logic                                btn_l,
    input  logic                                btn_r,
    input  logic                                btn_s,
    match_ctrl_if.master                        cards,
    output logic                                busy,
    output logic [$clog2(ROWS*COLS/2+1)-1:0]    pairs_left,
    output logic                                won
);
    localparam int N  = ROWS * COLS;
    localparam int XW = $clog2(N);
    localparam int PW = $clog2(N / 2 + 1);
    localparam int TW = $clog2(SHOW_CYCLES + 1);

    state_t        state, state_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [PW-1:0] pl_n;
    logic [XW-1:0] idx;
    logic [N-1:0]  cur;
    logic          s_r, ms_r, mf_r, ms_n, mf_n, hit;
    logic [IDW-1:0] ids [N];
    int            cnt, a, b;

    for (genvar k = 0; k < N; k++) begin : g_id
        assign ids[k] = cards.card_id[k*IDW +: IDW];
    end

    cursor_ctrl #(.ROWS(ROWS), .COLS(COLS)) u_cursor (
        .clk   (clk),
        .rst   (rst),
        .btn_u (btn_u),
        .btn_d (btn_d),
        .btn_l (btn_l),
        .btn_r (btn_r),
        .idx   (idx),
        .cur   (cur)
    );

    assign cnt       = popcount(MAXN'(cards.sel));
    assign a         = lo_idx(MAXN'(cards.sel));
    assign b         = hi_idx(MAXN'(cards.sel));
    assign hit       = (cnt == 2) && (ids[XW'(a)] == ids[XW'(b)]);
    assign pl_n      = (ms_n && pairs_left != '0) ? pairs_left - 1'b1 : pairs_left;
    assign cards.cur = cur;
    assign cards.s   = s_r;
    assign cards.ms  = ms_r;
    assign cards.mf  = mf_r;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // next state, show timer and judgement pulses
    always_comb begin
        state_n = state;
        tmr_n   = (state == HOLD) ? tmr - 1'b1 : TW'(SHOW_CYCLES - 1);
        ms_n    = 1'b0;
        mf_n    = 1'b0;
        case (state)
            IDLE:     state_n = (cnt == 1) ? ONE : (cnt >= 2) ? HOLD : IDLE;
            ONE:      state_n = (cnt == 0) ? IDLE : (cnt >= 2) ? HOLD : ONE;
            HOLD:     state_n = (tmr == '0) ? JUDGE : HOLD;
            JUDGE: begin
                ms_n    = hit;
                mf_n    = ~hit;
                state_n = WAIT_CLR;
            end
            WAIT_CLR: state_n = (cards.sel == '0) ? IDLE : WAIT_CLR;
            default:  state_n = IDLE;
        endcase
    end

    // registered outputs; select only passes when idle, unmoved, not won and on a live card
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr        <= '0;
            ms_r       <= 1'b0;
            mf_r       <= 1'b0;
            s_r        <= 1'b0;
            busy       <= 1'b0;
            won        <= 1'b0;
            pairs_left <= PW'(N / 2);
        end else begin
            tmr        <= tmr_n;
            ms_r       <= ms_n;
            mf_r       <= mf_n;
            s_r        <= btn_s & ~busy & ~(btn_u | btn_d | btn_l | btn_r) & ~won & ~cards.hidden[idx];
            busy       <= state_n inside {HOLD, JUDGE, WAIT_CLR};
            won        <= won | (pairs_left == '0);
            pairs_left <= pl_n;
        end
    end
endmodule
